// File: rtl/nitc_mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - Default widths and read latency used by the arbiter and its interface.
//   - Owner encoding: OWN_CPU = 0, OWN_HOST = 1. This is also the bit index of
//     each requester in the two-bit request vector.
//   - FSM state type for the single outstanding access.
package nitc_mem_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_READ_LAT = 1;

    // Wide enough for the largest legal read latency (4).
    localparam int unsigned LAT_W = 3;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the signals that connect the arbiter to the core, the host loader
// and the shared memory.
//   cpu_*  : core request channel (req/we/adr/wdata in, ack/rdata out)
//   host_* : loader request channel, plus host_lock for exclusive access
//   mem_*  : single-port memory bus (en/we/adr/wdata out, rdata in)
//   busy   : an access is in flight
//   owner  : requester that owns the access in flight (0 = CPU, 1 = HOST)
// Modport slave is the arbiter side. Modport master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned DATA_W = nitc_mem_pkg::DEF_DATA_W,
    parameter int unsigned ADDR_W = nitc_mem_pkg::DEF_ADDR_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic              host_lock;
    logic [ADDR_W-1:0] host_adr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_lock, host_adr, host_wdata,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_adr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_lock, host_adr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_adr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin choice.
//   req        : eligible requests, bit OWN_CPU = core, bit OWN_HOST = loader
//   last_grant : owner of the previous grant
//   valid      : at least one request present
//   grant      : chosen owner. On a tie, the requester not granted last wins.
module rr_arbiter2
    import nitc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |req;
        grant = OWN_CPU;
        case (req)
            2'b01:   grant = OWN_CPU;
            2'b10:   grant = OWN_HOST;
            2'b11:   grant = ~last_grant;
            default: grant = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core and a host loader onto one single-port memory. Only one
// access is outstanding at a time.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_arbiter_if.slave carrying the core, host and memory channels
// Write: request seen in IDLE at T, then mem_en and ack at T+1.
// Read:  request seen in IDLE at T, mem_en at T+1, then ack and rdata at T+1+READ_LAT.
// READ_LAT is legal in the range 1..4.
module mem_arbiter
    import nitc_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned READ_LAT = DEF_READ_LAT
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0] LatLoad = LAT_W'(READ_LAT);
    localparam logic [LAT_W-1:0] LatOne  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LatTwo  = LAT_W'(2);

    arb_state_e        state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              cpu_ack_q;
    logic              host_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic [1:0]        elig;
    logic              gnt_valid;
    logic              gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_done;

    // A held lock shuts the core out. It is only consulted when a grant is made,
    // so a core access already in flight still completes.
    assign elig[OWN_CPU]  = bus.cpu_req & ~bus.host_lock;
    assign elig[OWN_HOST] = bus.host_req;

    rr_arbiter2 u_rr (
        .req        (elig),
        .last_grant (last_grant_q),
        .valid      (gnt_valid),
        .grant      (gnt)
    );

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_adr   = bus.cpu_adr;
        sel_wdata = bus.cpu_wdata;
        if (gnt == OWN_HOST) begin
            sel_we    = bus.host_we;
            sel_adr   = bus.host_adr;
            sel_wdata = bus.host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= OWN_HOST;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            // Strobes default low. Each state raises them for one cycle only.
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        state_q      <= StIssue;
                        owner_q      <= gnt;
                        last_grant_q <= gnt;
                        we_q         <= sel_we;
                        adr_q        <= sel_adr;
                        wdata_q      <= sel_wdata;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= sel_we;
                        // A write completes in its issue cycle, so its ack is
                        // raised together with mem_en.
                        cpu_ack_q    <= sel_we & (gnt == OWN_CPU);
                        host_ack_q   <= sel_we & (gnt == OWN_HOST);
                    end
                end
                StIssue: begin
                    if (we_q) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= LatLoad;
                        if (LatLoad == LatOne) begin
                            cpu_ack_q  <= (owner_q == OWN_CPU);
                            host_ack_q <= (owner_q == OWN_HOST);
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - LatOne;
                    if (cnt_q == LatOne) begin
                        state_q <= StIdle;
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end else begin
                            host_rdata_q <= bus.mem_rdata;
                        end
                    end else if (cnt_q == LatTwo) begin
                        // Arm the ack so that it coincides with the final WAIT cycle.
                        cpu_ack_q  <= (owner_q == OWN_CPU);
                        host_ack_q <= (owner_q == OWN_HOST);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Final WAIT cycle. Read data is valid on mem_rdata in this cycle and is
    // passed straight through so that it lines up with the ack. The registered
    // copy then holds it until the same port completes another read.
    assign rd_done = (state_q == StWait) && (cnt_q == LatOne);

    assign bus.cpu_rdata  = (rd_done && owner_q == OWN_CPU) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.host_rdata = (rd_done && owner_q == OWN_HOST) ? bus.mem_rdata : host_rdata_q;

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.host_ack  = host_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_adr   = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with READ_LAT = 2. A transaction-level model predicts,
// for each access, its issue cycle and its completion cycle. Every cycle, all
// outputs are compared against that model. Directed scenarios run first, then
// randomised traffic.
module tb_mem_arbiter;
    import nitc_mem_pkg::*;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) b ();

    mem_arbiter #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .READ_LAT (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    function automatic logic [15:0] mem_init(input logic [7:0] a);
        return (a == 8'h20) ? 16'h1234 : {a, ~a};
    endfunction

    // Memory environment: a synchronous RAM with RL cycles of read latency.
    logic [15:0] ram [256];
    bit          ram_wr [256];
    logic [15:0] pipe [RL];
    always @(posedge clk) begin
        if (b.mem_en && b.mem_we) begin
            ram[b.mem_adr[7:0]]    <= b.mem_wdata;
            ram_wr[b.mem_adr[7:0]] <= 1'b1;
        end
        if (b.mem_en && !b.mem_we)
            pipe[0] <= ram_wr[b.mem_adr[7:0]] ? ram[b.mem_adr[7:0]] : mem_init(b.mem_adr[7:0]);
        else
            pipe[0] <= 16'hDEAD;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign b.mem_rdata = pipe[RL-1];

    int n_tests;
    int n_fail;
    int cyc;

    // Transaction-level reference state.
    bit          m_act;
    int          m_issue;
    int          m_done;
    logic        m_own;
    logic        m_we;
    logic        m_last;
    logic [15:0] m_adr;
    logic [15:0] m_wdata;
    logic [15:0] m_rd_val;
    logic [15:0] m_cpu_rd;
    logic [15:0] m_host_rd;
    logic [15:0] exp_mem [256];
    bit          exp_wr [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act     = 1'b0;
        m_last    = OWN_HOST;
        m_cpu_rd  = 16'h0;
        m_host_rd = 16'h0;
    endtask

    task automatic check_cycle();
        bit bz, iss, dn;
        bz  = m_act && cyc >= m_issue && cyc <= m_done;
        iss = m_act && cyc == m_issue;
        dn  = m_act && cyc == m_done;
        if (dn && !m_we) begin
            if (m_own == OWN_HOST) m_host_rd = m_rd_val;
            else m_cpu_rd = m_rd_val;
        end
        check_eq("busy", 32'(b.busy), 32'(bz));
        check_eq("mem_en", 32'(b.mem_en), 32'(iss));
        check_eq("mem_we", 32'(b.mem_we), 32'(iss && m_we));
        if (iss) begin
            check_eq("mem_adr", 32'(b.mem_adr), 32'(m_adr));
            if (m_we) check_eq("mem_wdata", 32'(b.mem_wdata), 32'(m_wdata));
        end
        if (bz) check_eq("owner", 32'(b.owner), 32'(m_own));
        check_eq("cpu_ack", 32'(b.cpu_ack), 32'(dn && m_own == OWN_CPU));
        check_eq("host_ack", 32'(b.host_ack), 32'(dn && m_own == OWN_HOST));
        check_eq("cpu_rdata", 32'(b.cpu_rdata), 32'(m_cpu_rd));
        check_eq("host_rdata", 32'(b.host_rdata), 32'(m_host_rd));
    endtask

    // Advance one clock. The model acts on the inputs seen at the edge, and the
    // outputs are compared at the following falling edge.
    task automatic step();
        logic ce, he;
        @(posedge clk);
        if (reset) begin
            if (m_act && cyc == m_issue) begin
                if (m_we) begin
                    exp_mem[m_adr[7:0]] = m_wdata;
                    exp_wr[m_adr[7:0]]  = 1'b1;
                end else begin
                    m_rd_val = exp_wr[m_adr[7:0]] ? exp_mem[m_adr[7:0]] : mem_init(m_adr[7:0]);
                end
            end
            if (!(m_act && cyc >= m_issue && cyc <= m_done)) begin
                ce = b.cpu_req & ~b.host_lock;
                he = b.host_req;
                if (ce | he) begin
                    m_own   = (ce & he) ? ~m_last : he;
                    m_last  = m_own;
                    m_act   = 1'b1;
                    m_issue = cyc + 1;
                    if (m_own == OWN_HOST) begin
                        m_we = b.host_we; m_adr = b.host_adr; m_wdata = b.host_wdata;
                    end else begin
                        m_we = b.cpu_we; m_adr = b.cpu_adr; m_wdata = b.cpu_wdata;
                    end
                    m_done = m_issue + (m_we ? 0 : RL);
                end
            end
        end
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_busy", 32'(b.busy), 32'(0));
        check_eq("rst_owner", 32'(b.owner), 32'(0));
        check_eq("rst_cpu_ack", 32'(b.cpu_ack), 32'(0));
        check_eq("rst_host_ack", 32'(b.host_ack), 32'(0));
        check_eq("rst_mem_en", 32'(b.mem_en), 32'(0));
        check_eq("rst_mem_we", 32'(b.mem_we), 32'(0));
        check_eq("rst_mem_adr", 32'(b.mem_adr), 32'(0));
        check_eq("rst_mem_wdata", 32'(b.mem_wdata), 32'(0));
        check_eq("rst_cpu_rdata", 32'(b.cpu_rdata), 32'(0));
        check_eq("rst_host_rdata", 32'(b.host_rdata), 32'(0));
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    task automatic new_op(input bit host);
        logic        w;
        logic [15:0] a, d;
        w = 1'($urandom_range(1));
        a = 16'($urandom_range(255));
        d = 16'($urandom);
        if (host) begin
            b.host_req = 1'b1; b.host_we = w; b.host_adr = a; b.host_wdata = d;
        end else begin
            b.cpu_req = 1'b1; b.cpu_we = w; b.cpu_adr = a; b.cpu_wdata = d;
        end
    endtask

    task automatic drive_random();
        bit cpu_done, host_done;
        cpu_done  = m_act && cyc == m_done && m_own == OWN_CPU;
        host_done = m_act && cyc == m_done && m_own == OWN_HOST;
        if (b.cpu_req) begin
            if (cpu_done) begin
                if ($urandom_range(1) == 0) new_op(1'b0);
                else b.cpu_req = 1'b0;
            end else if ($urandom_range(15) == 0) begin
                b.cpu_req = 1'b0;
            end
        end else if ($urandom_range(3) == 0) begin
            new_op(1'b0);
        end
        if (b.host_req) begin
            if (host_done) begin
                if ($urandom_range(1) == 0) new_op(1'b1);
                else b.host_req = 1'b0;
            end else if ($urandom_range(15) == 0) begin
                b.host_req = 1'b0;
            end
        end else if ($urandom_range(3) == 0) begin
            new_op(1'b1);
        end
        if ($urandom_range(11) == 0) b.host_lock = ~b.host_lock;
    endtask

    initial begin
        int  k, lat, n_cpu, n_host;
        bit  got, first_cpu;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        b.cpu_req = 1'b0; b.cpu_we = 1'b0; b.cpu_adr = '0; b.cpu_wdata = '0;
        b.host_req = 1'b0; b.host_we = 1'b0; b.host_lock = 1'b0;
        b.host_adr = '0; b.host_wdata = '0;
        model_reset();
        @(negedge clk);
        apply_reset(2);

        // Core write: mem strobe and ack one cycle after the request.
        b.cpu_req = 1'b1; b.cpu_we = 1'b1; b.cpu_adr = 16'h0010; b.cpu_wdata = 16'hBEEF;
        step();
        check_eq("d033_mem_en", 32'(b.mem_en), 32'(1));
        check_eq("d033_mem_we", 32'(b.mem_we), 32'(1));
        check_eq("d033_mem_adr", 32'(b.mem_adr), 32'h0010);
        check_eq("d033_mem_wdata", 32'(b.mem_wdata), 32'hBEEF);
        check_eq("d033_cpu_ack", 32'(b.cpu_ack), 32'(1));
        check_eq("d033_host_ack", 32'(b.host_ack), 32'(0));
        b.cpu_req = 1'b0;
        step();

        // Host read: ack and data RL+1 cycles after the request.
        b.host_req = 1'b1; b.host_we = 1'b0; b.host_adr = 16'h0020;
        step();
        check_eq("d034_ack_t1", 32'(b.host_ack), 32'(0));
        step();
        check_eq("d034_ack_t2", 32'(b.host_ack), 32'(0));
        step();
        check_eq("d034_ack_t3", 32'(b.host_ack), 32'(1));
        check_eq("d034_host_rdata", 32'(b.host_rdata), 32'h1234);
        check_eq("d034_cpu_rdata", 32'(b.cpu_rdata), 32'h0);
        b.host_req = 1'b0;
        step();

        // Core read whose request is withdrawn during the issue cycle.
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_adr = 16'h0010;
        step();
        b.cpu_req = 1'b0;
        n_cpu = 0;
        repeat (5) begin
            step();
            if (b.cpu_ack) n_cpu++;
        end
        check_eq("d038_ack_count", 32'(n_cpu), 32'(1));
        check_eq("d038_idle", 32'(b.busy), 32'(0));
        check_eq("d038_cpu_rdata", 32'(b.cpu_rdata), 32'hBEEF);

        // Reset during WAIT aborts the read, and the retried read has normal latency.
        b.cpu_req = 1'b1; b.cpu_we = 1'b0; b.cpu_adr = 16'h0020;
        step();
        step();
        apply_reset(1);
        check_eq("d037_no_ack", 32'(b.cpu_ack), 32'(0));
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            lat++;
            if (b.cpu_ack) got = 1'b1;
        end
        check_eq("d037_latency", 32'(lat), 32'(1 + RL));
        check_eq("d037_cpu_rdata", 32'(b.cpu_rdata), 32'h1234);
        b.cpu_req = 1'b0;
        step();

        // Continuous requests from both sides alternate, starting with the core.
        apply_reset(1);
        b.cpu_req = 1'b1; b.cpu_we = 1'b1; b.cpu_adr = 16'h0040; b.cpu_wdata = 16'h1111;
        b.host_req = 1'b1; b.host_we = 1'b1; b.host_adr = 16'h0041; b.host_wdata = 16'h2222;
        k = 0;
        repeat (8) begin
            step();
            if (b.cpu_ack || b.host_ack) begin
                check_eq($sformatf("d035_grant%0d", k), 32'(b.host_ack), 32'(k % 2));
                k++;
            end
        end
        check_eq("d035_count", 32'(k), 32'(4));

        // With the lock held only host accesses issue; the core wins after release.
        b.host_lock = 1'b1;
        b.cpu_adr = 16'h0030; b.host_adr = 16'h0031;
        n_cpu = 0;
        n_host = 0;
        repeat (6) begin
            step();
            if (b.cpu_ack) n_cpu++;
            if (b.host_ack) n_host++;
        end
        check_eq("d036_cpu_locked", 32'(n_cpu), 32'(0));
        check_eq("d036_host_count", 32'(n_host), 32'(3));
        b.host_lock = 1'b0;
        got = 1'b0;
        first_cpu = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            if (b.cpu_ack || b.host_ack) begin
                got = 1'b1;
                first_cpu = b.cpu_ack;
            end
        end
        check_eq("d036_unlock_cpu", 32'(first_cpu), 32'(1));
        b.cpu_req = 1'b0; b.host_req = 1'b0;
        step();
        step();

        // Randomised traffic with lock toggling and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(699) == 0) begin
                apply_reset(1 + int'($urandom_range(1)));
            end else begin
                drive_random();
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter READ_LAT, default 1, memory read latency in cycles, legal 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req/cpu_we  input  1 each  core access request / write enable.
REQ-007 SHALL have ports cpu_adr  input  ADDR_W and cpu_wdata  input  DATA_W  core address / write data.
REQ-008 SHALL have ports cpu_ack  output  1 and cpu_rdata  output  DATA_W  completion pulse / read data.
REQ-009 SHALL have ports host_req, host_we, host_lock  input  1 each  loader request, write enable, exclusive-access hold.
REQ-010 SHALL have ports host_adr  input  ADDR_W, host_wdata  input  DATA_W, host_ack  output  1, host_rdata  output  DATA_W.
REQ-011 SHALL have ports mem_en, mem_we  output  1 each; mem_adr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W.
REQ-012 SHALL have ports busy  output  1 and owner  output  1 (0=CPU, 1=HOST).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT; one outstanding access at a time.
REQ-014 IDLE: if any eligible request, grant one, register owner/adr/we/wdata, go to ISSUE; else stay.
REQ-015 Eligibility: host_req always eligible; cpu_req eligible only while host_lock=0.
REQ-016 Both eligible in IDLE: round-robin, grant the requester not granted last; last_grant updates on every grant.
REQ-017 ISSUE: mem_en=1 for exactly this cycle, with mem_we/mem_adr/mem_wdata from registered values.
REQ-018 ISSUE with write: owner's ack=1 in the same cycle, next state IDLE (write latency: req seen at T, ack at T+1).
REQ-019 ISSUE with read: next state WAIT, latency counter loaded with READ_LAT.
REQ-020 WAIT: counter decrements each cycle; on final cycle owner's ack=1, owner's rdata=mem_rdata, next IDLE (read: req at T, ack at T+1+READ_LAT).
REQ-021 ack SHALL be a single-cycle pulse only to the owner; the non-owner's ack stays 0.
REQ-022 rdata outputs SHALL hold last returned value until the next read completion for that port.
REQ-023 Requester SHALL hold req and operands stable until ack; req held high after ack counts as a new request in the following IDLE.
REQ-024 Req dropped before ack: the granted access still completes and ack still pulses.
REQ-025 host_lock asserted mid-CPU-access: CPU access completes; lock takes effect at next IDLE decision.
REQ-026 mem_en=0 and mem_we=0 in IDLE and WAIT; busy=1 in ISSUE and WAIT.
REQ-027 owner SHALL reflect the registered grant, valid while busy=1.

Reset
REQ-028 reset low SHALL asynchronously force state=IDLE, counter=0, last_grant=HOST (first tie goes to CPU).
REQ-029 During/after reset: all acks 0, mem_en 0, mem_we 0, busy 0, owner 0, rdata outputs 0, mem_adr/mem_wdata 0.
REQ-030 Reset mid-access SHALL abort the access with no ack; first access after release starts from IDLE.

Structure
REQ-031 A shared package (nitc_mem_pkg) SHALL hold the FSM state enum, owner encoding (OWN_CPU=0, OWN_HOST=1) and default widths.
REQ-032 Round-robin choice SHALL live in one sub-module rr_arbiter2 (two requests, last_grant in, grant out), combinational.

Verification
REQ-033 CPU write adr=0x0010 data=0xBEEF at T -> mem_en=mem_we=1, mem_adr=0x0010 at T+1, cpu_ack at T+1, host_ack 0.
REQ-034 READ_LAT=2, host read adr=0x0020, mem returns 0x1234 -> host_ack and host_rdata=0x1234 at T+3, cpu_rdata unchanged.
REQ-035 Both request continuously after reset -> grants alternate CPU, HOST, CPU, HOST; each ack once per access.
REQ-036 host_lock=1 with cpu_req and host_req -> only host accesses issued; CPU granted first IDLE after lock drops.
REQ-037 reset pulsed low during WAIT -> no ack, busy=0 immediately, next CPU read completes with normal latency.
REQ-038 cpu_req dropped in ISSUE of a read -> read still completes, cpu_ack pulses once, FSM returns to IDLE.
